bus_grant_sequencer: RTL and testbench

Upstream stage of the bus-select encoder. It captures a multi-bit set of "register-out" requests from control logic and grants them onto the bus one at a time in fixed lowest-index-first order. Each grant is a registered one-hot 32-bit word, so the encoder only ever sees a legal one-hot input or zero. A consumer-driven advance handshake, with a minimum dwell per grant, paces the sequence, and a done pulse marks the end of each batch.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_grant_sequencer_lowest_onehot.sv | 26 ++
 rtl/bus_grant_sequencer.sv | 109 ++++++++++
 tb/tb_bus_grant_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus-select path.
//   state_t   : sequencer FSM states
//   BUS_SEL_W : width of the encoded bus-select index downstream
//   GRANT_W   : width of the one-hot grant word
//   DWELL_W   : width of the per-grant dwell counter
//   GCOUNT_W  : width of the retired-grant counter
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BUS_SEL_W = 5;
  localparam int GRANT_W   = 32;
  localparam int DWELL_W   = 4;
  localparam int GCOUNT_W  = 6;

endpackage

// File: rtl/bus_grant_sequencer_lowest_onehot.sv
// Isolates the lowest set bit of an NREQ-bit vector and zero-extends the
// result to the grant width. Purely combinational.
//   x : NREQ-bit input set
//   y : GRANT_W-bit one-hot of the lowest set bit of x, 0 when x is 0
module lowest_onehot
  import bus_pkg::*;
#(
  parameter int NREQ = 24
) (
  input  logic [NREQ-1:0]    x,
  output logic [GRANT_W-1:0] y
);

  logic [NREQ-1:0] iso;

  // Two's complement trick: x & -x keeps only the lowest set bit.
  assign iso = x & (~x + NREQ'(1));

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    y           = '0;
    y[NREQ-1:0] = iso;
  end

endmodule

// File: rtl/bus_grant_sequencer.sv
// Captures a set of register-out requests and grants them onto the bus one
// at a time, lowest index first, as a registered one-hot word.
//   clk    : rising-edge clock
//   clr    : asynchronous active-high reset
//   start  : batch request, sampled only in IDLE
//   req    : request set captured on an accepted start
//   adv    : consumer has used the current grant
//   grant  : registered one-hot grant word (0 when idle)
//   busy   : high while granting
//   done   : one-cycle pulse at end of batch
//   gcount : grants retired in the current or most recent batch
module bus_grant_sequencer
  import bus_pkg::*;
#(
  parameter int NREQ  = 24,
  parameter int DWELL = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [NREQ-1:0]     req,
  input  logic                adv,
  output logic [GRANT_W-1:0]  grant,
  output logic                busy,
  output logic                done,
  output logic [GCOUNT_W-1:0] gcount
);

  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL - 1);

  state_t              state;
  state_t              next_state;
  logic [NREQ-1:0]     pending;
  logic [NREQ-1:0]     pending_next;
  logic [DWELL_W-1:0]  dwell;
  logic [NREQ-1:0]     onehot_in;
  logic [GRANT_W-1:0]  onehot_out;
  logic                start_ok;
  logic                adv_ok;

  assign start_ok     = (state == ST_IDLE) && start;
  assign adv_ok       = (state == ST_GRANT) && (dwell == '0) && adv;
  assign pending_next = pending & ~grant[NREQ-1:0];

  // The isolator sees either the fresh request set or what is left after
  // retiring the current grant; its output feeds the grant register
  // directly. An empty remainder yields 0, which clears grant at batch end.
  assign onehot_in = (state == ST_IDLE) ? req : pending_next;

  lowest_onehot #(.NREQ(NREQ)) u_lowest (
    .x (onehot_in),
    .y (onehot_out)
  );

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = (req != '0) ? ST_GRANT : ST_DONE;
      end
      ST_GRANT: begin
        if (adv_ok && (pending_next == '0)) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    busy = (state == ST_GRANT);
    done = (state == ST_DONE);
  end

  // Datapath: pending set, grant word, dwell timer, retired-grant count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending <= '0;
      grant   <= '0;
      dwell   <= '0;
      gcount  <= '0;
    end else if (start_ok) begin
      pending <= req;
      grant   <= onehot_out;
      dwell   <= DWELL_RELOAD;
      gcount  <= '0;
    end else if (state == ST_GRANT) begin
      if (dwell != '0) begin
        // adv during dwell is dropped, not remembered
        dwell <= dwell - DWELL_W'(1);
      end else if (adv) begin
        pending <= pending_next;
        grant   <= onehot_out;
        dwell   <= DWELL_RELOAD;
        gcount  <= gcount + GCOUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Directed bench for bus_grant_sequencer: one instance with DWELL=1 and one
// with DWELL=3, both NREQ=24, sharing clock and reset.
module tb_bus_grant_sequencer;

  logic        clk = 1'b0;
  logic        clr;

  logic        start, adv;
  logic [23:0] req;
  logic [31:0] grant;
  logic        busy, done;
  logic [5:0]  gcount;

  logic        start3, adv3;
  logic [23:0] req3;
  logic [31:0] grant3;
  logic        busy3, done3;
  logic [5:0]  gcount3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_grant_sequencer #(.NREQ(24), .DWELL(1)) u_dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .req    (req),
    .adv    (adv),
    .grant  (grant),
    .busy   (busy),
    .done   (done),
    .gcount (gcount)
  );

  bus_grant_sequencer #(.NREQ(24), .DWELL(3)) u_dut3 (
    .clk    (clk),
    .clr    (clr),
    .start  (start3),
    .req    (req3),
    .adv    (adv3),
    .grant  (grant3),
    .busy   (busy3),
    .done   (done3),
    .gcount (gcount3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_seq [4];

  initial begin
    clr = 1'b1; start = 0; adv = 0; req = '0;
    start3 = 0; adv3 = 0; req3 = '0;
    exp_seq[0] = 32'h1; exp_seq[1] = 32'h40;
    exp_seq[2] = 32'h200; exp_seq[3] = 32'h800000;

    tick(); tick();
    check("rst_grant", grant, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_gcount", {26'b0, gcount}, 32'h0);
    clr = 1'b0;
    tick();

    // Single request
    start = 1; req = 24'h000010; adv = 1;
    tick();
    start = 0;
    check("single_grant", grant, 32'h10);
    check("single_busy", {31'b0, busy}, 32'h1);
    tick();
    check("single_grant_clr", grant, 32'h0);
    check("single_done", {31'b0, done}, 32'h1);
    check("single_gcount", {26'b0, gcount}, 32'd1);
    tick();
    check("single_done_pulse", {31'b0, done}, 32'h0);
    check("single_gcount_hold", {26'b0, gcount}, 32'd1);

    // Multi-request ordering
    start = 1; req = 24'h800241; adv = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 0;
      check($sformatf("multi_grant%0d", i), grant, exp_seq[i]);
      check($sformatf("multi_nodone%0d", i), {31'b0, done}, 32'h0);
    end
    tick();
    check("multi_done", {31'b0, done}, 32'h1);
    check("multi_grant_end", grant, 32'h0);
    check("multi_gcount", {26'b0, gcount}, 32'd4);
    tick();

    // Stall with adv low; start pulsed mid-stall is ignored
    start = 1; req = 24'h00000C; adv = 0;
    tick();
    start = 0;
    check("stall_first", grant, 32'h4);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin start = 1; req = 24'h000001; end
      else start = 0;
      tick();
      check($sformatf("stall_grant%0d", i), grant, 32'h4);
      check($sformatf("stall_busy%0d", i), {31'b0, busy}, 32'h1);
      check($sformatf("stall_nodone%0d", i), {31'b0, done}, 32'h0);
    end
    start = 0; adv = 1;
    tick();
    check("stall_next", grant, 32'h8);
    check("stall_gcount1", {26'b0, gcount}, 32'd1);
    tick();
    check("stall_done", {31'b0, done}, 32'h1);
    check("stall_gcount2", {26'b0, gcount}, 32'd2);
    tick();

    // Empty batch, then start held through DONE: ignored there, accepted in IDLE
    start = 1; req = 24'h0; adv = 0;
    tick();
    check("empty_done", {31'b0, done}, 32'h1);
    check("empty_grant", grant, 32'h0);
    check("empty_busy", {31'b0, busy}, 32'h0);
    check("empty_gcount", {26'b0, gcount}, 32'd0);
    req = 24'h000002;
    tick();
    check("b2b_idle_grant", grant, 32'h0);
    check("b2b_idle_busy", {31'b0, busy}, 32'h0);
    tick();
    start = 0; adv = 1;
    check("b2b_grant", grant, 32'h2);
    tick();
    check("b2b_done", {31'b0, done}, 32'h1);
    tick();

    // Asynchronous abort mid-batch
    start = 1; req = 24'h00000F; adv = 1;
    tick();
    start = 0;
    check("abort_g0", grant, 32'h1);
    tick();
    check("abort_g1", grant, 32'h2);
    check("abort_gc1", {26'b0, gcount}, 32'd1);
    #2 clr = 1'b1;
    #1;
    check("abort_grant", grant, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_gcount", {26'b0, gcount}, 32'd0);
    tick();
    check("abort_nodone", {31'b0, done}, 32'h0);
    clr = 1'b0;
    tick();
    check("abort_nodone2", {31'b0, done}, 32'h0);
    start = 1; req = 24'h000020; adv = 1;
    tick();
    start = 0;
    check("post_abort_grant", grant, 32'h20);
    tick();
    check("post_abort_done", {31'b0, done}, 32'h1);
    check("post_abort_gcount", {26'b0, gcount}, 32'd1);
    tick();

    // DWELL=3, adv held high: each grant held 3 cycles, busy 6 cycles
    start3 = 1; req3 = 24'h000006; adv3 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start3 = 0;
      check($sformatf("dw_grant%0d", i), grant3, (i < 3) ? 32'h2 : 32'h4);
      check($sformatf("dw_busy%0d", i), {31'b0, busy3}, 32'h1);
    end
    tick();
    check("dw_done", {31'b0, done3}, 32'h1);
    check("dw_busy_end", {31'b0, busy3}, 32'h0);
    check("dw_gcount", {26'b0, gcount3}, 32'd2);
    tick();

    // DWELL=3, adv pulsed only while dwell is nonzero: dropped, grant holds
    start3 = 1; req3 = 24'h000006; adv3 = 0;
    tick();
    start3 = 0; adv3 = 1;       // dwell=2 in this cycle
    tick();
    adv3 = 0;                   // dwell=1, then dwell=0 with adv low
    tick(); tick(); tick();
    check("dw_drop_grant", grant3, 32'h2);
    check("dw_drop_gcount", {26'b0, gcount3}, 32'd0);
    adv3 = 1;
    tick();
    check("dw_after_adv", grant3, 32'h4);
    check("dw_after_gcount", {26'b0, gcount3}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
